pe_row_byte_fifo: RTL and testbench

//  Byte-granular receive FIFO on the PE-row side of the token engine's FIFO push/pop protocol
//   (ifmap / ipsum rows of the conv array).

---
 rtl/pe_row_byte_fifo.sv | 111 +++++++++++
 tb/tb_pe_row_byte_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_row_byte_fifo.sv
// Byte-granular PE-row receive FIFO: 1- or 4-byte pushes/pops, first-word fall-through head.
// Define PE_FIFO_ERR_EN to build the sticky overflow/underflow flags and their simulation checks.
module pe_row_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_reset_i,
  input  logic             push_en_i,
  input  logic             push_mod_i,
  input  logic [31:0]      push_data_i,
  input  logic             pop_en_i,
  input  logic             pop_mod_i,
  output logic [31:0]      pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             word_avail_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;
  logic [2:0]       push_n, pop_n;

  // Full is judged for a word push, so a byte push is refused at the same threshold.
  assign full_o       = (count_q > CNT_W'(DEPTH - 4));
  assign empty_o      = (count_q == '0);
  assign word_avail_o = (count_q >= CNT_W'(4));
  assign count_o      = count_q;

  assign push_ok = push_en_i & ~full_o;
  assign pop_ok  = pop_en_i & (pop_mod_i ? word_avail_o : ~empty_o);
  assign push_n  = push_ok ? (push_mod_i ? 3'd4 : 3'd1) : 3'd0;
  assign pop_n   = pop_ok  ? (pop_mod_i  ? 3'd4 : 3'd1) : 3'd0;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (fifo_reset_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !fifo_reset_i) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || push_mod_i)
          mem_q[wr_ptr_q + PTR_W'(k)] <= push_data_i[8*k +: 8];
      end
    end
  end

  // Bytes beyond the stored count read as zero, which also gives a zero head out of reset.
  always_comb begin
    pop_data_o = '0;
    for (int k = 0; k < 4; k++) begin
      if ((k == 0 || pop_mod_i) && (count_q > CNT_W'(k)))
        pop_data_o[8*k +: 8] = mem_q[rd_ptr_q + PTR_W'(k)];
    end
  end

`ifdef PE_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_en_i && full_o) overflow_q  <= 1'b1;
      if (pop_en_i && !pop_ok) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && push_en_i && full_o)  $error("pe_row_byte_fifo: push dropped while full");
    if (!rst && pop_en_i && !pop_ok)  $error("pe_row_byte_fifo: pop rejected, too few bytes");
  end
`endif
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_pe_row_byte_fifo.sv
// Bench for pe_row_byte_fifo: constant vector table, hand-built corner sequences and a byte-queue scoreboard.
module tb_pe_row_byte_fifo;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef PE_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fifo_reset_i = 1'b0;
  logic             push_en_i = 1'b0;
  logic             push_mod_i = 1'b0;
  logic [31:0]      push_data_i = '0;
  logic             pop_en_i = 1'b0;
  logic             pop_mod_i = 1'b0;
  logic [31:0]      pop_data_o;
  logic             full_o, empty_o, word_avail_o;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o, underflow_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_q[$];

  pe_row_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fifo_reset_i(fifo_reset_i),
    .push_en_i(push_en_i), .push_mod_i(push_mod_i), .push_data_i(push_data_i),
    .pop_en_i(pop_en_i), .pop_mod_i(pop_mod_i), .pop_data_o(pop_data_o),
    .full_o(full_o), .empty_o(empty_o), .word_avail_o(word_avail_o),
    .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus: head data checked before the edge, status after it.
  task automatic step(input logic pe, input logic pm, input logic [31:0] pd,
                      input logic oe, input logic om, input logic [31:0] ep,
                      input int ec, input logic ef, input string tag);
    @(negedge clk);
    push_en_i = pe; push_mod_i = pm; push_data_i = pd;
    pop_en_i = oe;  pop_mod_i = om;
    #1;
    if (oe) chk({tag, ".pop"}, pop_data_o, ep);
    @(posedge clk);
    #1;
    push_en_i = 1'b0; pop_en_i = 1'b0;
    chk({tag, ".cnt"}, 32'(count_o), 32'(ec));
    chk({tag, ".full"}, 32'(full_o), 32'(ef));
    chk({tag, ".empty"}, 32'(empty_o), 32'(ec == 0));
    chk({tag, ".wavail"}, 32'(word_avail_o), 32'(ec >= 4));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic pe; logic pm; logic [31:0] pd;
    logic oe; logic om; logic [31:0] ep;
    int ec; logic ef;
  } vec_t;

  vec_t tbl[34];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 32'h0,        4,  1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h000000AA, 3,  1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h000000BB, 2,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h000000CC, 1,  1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h000000DD, 0,  1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h99887711, 1'b0, 1'b0, 32'h0,        1,  1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00000011, 1,  1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000011, 0,  1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h03020100, 1'b0, 1'b0, 32'h0,        4,  1'b0};
    tbl[9]  = '{1'b1, 1'b1, 32'h07060504, 1'b0, 1'b0, 32'h0,        8,  1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h0B0A0908, 1'b0, 1'b0, 32'h0,        12, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0, 32'h0,        13, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 32'h000000EE, 1'b0, 1'b0, 32'h0,        13, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h03020100, 9,  1'b0};
    tbl[14] = '{1'b1, 1'b1, 32'h100F0E0D, 1'b0, 1'b0, 32'h0,        13, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'hEEEEEEEE, 1'b1, 1'b1, 32'h07060504, 9,  1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0B0A0908, 5,  1'b0};
    tbl[17] = '{1'b1, 1'b1, 32'h14131211, 1'b0, 1'b0, 32'h0,        9,  1'b0};
    tbl[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0000000C, 8,  1'b0};
    tbl[19] = '{1'b1, 1'b1, 32'h18171615, 1'b1, 1'b0, 32'h0000000D, 11, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h11100F0E, 7,  1'b0};
    tbl[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h15141312, 3,  1'b0};
    tbl[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000016, 2,  1'b0};
    tbl[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000017, 1,  1'b0};
    tbl[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h00000018, 0,  1'b0};
    tbl[25] = '{1'b1, 1'b1, 32'hA3A2A1A0, 1'b0, 1'b0, 32'h0,        4,  1'b0};
    tbl[26] = '{1'b1, 1'b1, 32'hA7A6A5A4, 1'b0, 1'b0, 32'h0,        8,  1'b0};
    tbl[27] = '{1'b1, 1'b1, 32'hABAAA9A8, 1'b0, 1'b0, 32'h0,        12, 1'b0};
    tbl[28] = '{1'b1, 1'b1, 32'hAFAEADAC, 1'b0, 1'b0, 32'h0,        16, 1'b1};
    tbl[29] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        16, 1'b1};
    tbl[30] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA3A2A1A0, 12, 1'b0};
    tbl[31] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hA7A6A5A4, 8,  1'b0};
    tbl[32] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hABAAA9A8, 4,  1'b0};
    tbl[33] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hAFAEADAC, 0,  1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst.cnt", 32'(count_o), 32'd0);
    chk("rst.empty", 32'(empty_o), 32'd1);
    chk("rst.full", 32'(full_o), 32'd0);
    chk("rst.wavail", 32'(word_avail_o), 32'd0);
    chk("rst.pop", pop_data_o, 32'd0);
    chk("rst.ovf", 32'(overflow_o), 32'd0);
    chk("rst.unf", 32'(underflow_o), 32'd0);

    for (int i = 0; i < 34; i++)
      step(tbl[i].pe, tbl[i].pm, tbl[i].pd, tbl[i].oe, tbl[i].om, tbl[i].ep,
           tbl[i].ec, tbl[i].ef, $sformatf("v%0d", i));
    chk("tbl.ovf", 32'(overflow_o), 32'(ERR_EN));
    chk("tbl.unf", 32'(underflow_o), 32'(ERR_EN));

    // Wrap from fresh pointers: the last word straddles index 15 -> 0
    do_reset();
    step(1'b1, 1'b0, 32'h01, 1'b0, 1'b0, 32'h0, 1, 1'b0, "w.pb0");
    step(1'b1, 1'b0, 32'h02, 1'b0, 1'b0, 32'h0, 2, 1'b0, "w.pb1");
    step(1'b1, 1'b0, 32'h03, 1'b0, 1'b0, 32'h0, 3, 1'b0, "w.pb2");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h01, 2, 1'b0, "w.ob0");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h02, 1, 1'b0, "w.ob1");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h03, 0, 1'b0, "w.ob2");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0, 1'b0, 32'h0,
           4*(i+1), (i == 3), $sformatf("w.pw%0d", i));
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)},
           12 - 4*i, 1'b0, $sformatf("w.ow%0d", i));

    // Synchronous clear beats a push in the same cycle
    step(1'b1, 1'b1, 32'h44332211, 1'b0, 1'b0, 32'h0, 4, 1'b0, "fr.pw");
    step(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0, 5, 1'b0, "fr.pb");
    @(negedge clk);
    fifo_reset_i = 1'b1; push_en_i = 1'b1; push_mod_i = 1'b1; push_data_i = 32'h77777777;
    @(posedge clk);
    #1;
    fifo_reset_i = 1'b0; push_en_i = 1'b0;
    chk("fr.cnt", 32'(count_o), 32'd0);
    chk("fr.empty", 32'(empty_o), 32'd1);
    chk("fr.ovf", 32'(overflow_o), 32'd0);
    step(1'b1, 1'b1, 32'h0C0B0A09, 1'b0, 1'b0, 32'h0, 4, 1'b0, "fr.pw2");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C0B0A09, 0, 1'b0, "fr.ow2");

    // Asynchronous reset mid-push, checked before any clock edge
    step(1'b1, 1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 32'h0, 4, 1'b0, "ar.pw");
    @(negedge clk);
    push_en_i = 1'b1; push_mod_i = 1'b1; push_data_i = 32'h12345678; pop_mod_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("ar.cnt", 32'(count_o), 32'd0);
    chk("ar.empty", 32'(empty_o), 32'd1);
    chk("ar.full", 32'(full_o), 32'd0);
    chk("ar.wavail", 32'(word_avail_o), 32'd0);
    chk("ar.pop", pop_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0; push_en_i = 1'b0;

    // Random traffic against a byte-queue scoreboard
    sb_q.delete();
    for (int n = 0; n < 400; n++) begin
      logic pe, pm, oe, om, acc_push, acc_pop;
      logic [31:0] pd, exp;
      pe = ($urandom_range(0, 99) < 55); pm = $urandom_range(0, 1) != 0;
      oe = ($urandom_range(0, 99) < 50); om = $urandom_range(0, 1) != 0;
      pd = $urandom;
      exp = '0;
      for (int k = 0; k < 4; k++)
        if ((k == 0 || om) && k < sb_q.size()) exp[8*k +: 8] = sb_q[k];
      acc_push = pe && (sb_q.size() <= DEPTH - 4);
      acc_pop  = oe && (sb_q.size() >= (om ? 4 : 1));
      @(negedge clk);
      push_en_i = pe; push_mod_i = pm; push_data_i = pd; pop_en_i = oe; pop_mod_i = om;
      #1;
      if (oe) chk("sb.pop", pop_data_o, exp);
      if (acc_pop) repeat (om ? 4 : 1) void'(sb_q.pop_front());
      if (acc_push) for (int k = 0; k < (pm ? 4 : 1); k++) sb_q.push_back(pd[8*k +: 8]);
      @(posedge clk);
      #1;
      chk("sb.cnt", 32'(count_o), 32'(sb_q.size()));
    end
    push_en_i = 1'b0; pop_en_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
